// File: rtl/xenos_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : xenos_watchdog
//  Description : Window watchdog and fault-source conditioner feeding the
//                XENOS state machine. Converts a kick heartbeat into a
//                single-cycle wdg_trigger pulse and debounces, latches and
//                masks raw fault sources into the level fault_input.
//  Revision    : 1.0 - initial release
// ============================================================================
module xenos_watchdog #(
    parameter int          N_SRC    = 4,
    parameter logic [15:0] WIN_MIN  = 16'd50,
    parameter logic [15:0] TIMEOUT  = 16'd1000,
    parameter logic [3:0]  DEBOUNCE = 4'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             kick,
    input  logic [N_SRC-1:0] fault_src,
    input  logic [N_SRC-1:0] fault_mask,
    input  logic             fault_clr,
    output logic             wdg_trigger,
    output logic             fault_input,
    output logic [N_SRC-1:0] fault_status,
    output logic             early_kick,
    output logic [15:0]      wdg_count,
    output logic [7:0]       expire_cnt
);

    // Watchdog states
    localparam logic [1:0] c_st_disabled = 2'd0;
    localparam logic [1:0] c_st_closed   = 2'd1;
    localparam logic [1:0] c_st_open     = 2'd2;

    // Last counter value before expiry fires
    localparam logic [15:0] c_last_cnt   = TIMEOUT - 16'd1;
    // Debounce count one short of latching; the set fires on the step to DEBOUNCE
    localparam logic [3:0]  c_db_pre     = DEBOUNCE - 4'd1;

    logic [1:0]       r_state;
    logic [15:0]      r_count;
    logic             r_trigger;
    logic             r_early;
    logic [7:0]       r_expire;
    logic [N_SRC-1:0] r_status;
    logic             r_fault_input;

    logic [1:0]       w_state_nxt;
    logic [15:0]      w_count_nxt;
    logic [15:0]      w_count_inc;
    logic             w_trig_nxt;
    logic             w_early_set;
    logic [N_SRC-1:0] w_set;

    assign w_count_inc = r_count + 16'd1;

    // Watchdog next-state: enable drop overrides everything, including a pending expiry
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_trig_nxt  = 1'b0;
        w_early_set = 1'b0;
        if (!enable) begin
            w_state_nxt = c_st_disabled;
            w_count_nxt = 16'd0;
        end else begin
            case (r_state)
                c_st_disabled: begin
                    w_state_nxt = c_st_closed;
                    w_count_nxt = 16'd0;
                end
                c_st_closed: begin
                    if (kick) begin
                        w_early_set = 1'b1;
                        w_trig_nxt  = 1'b1;
                        w_count_nxt = 16'd0;
                    end else begin
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == WIN_MIN) begin
                            w_state_nxt = c_st_open;
                        end
                    end
                end
                c_st_open: begin
                    if (kick) begin
                        w_count_nxt = 16'd0;
                        w_state_nxt = c_st_closed;
                    end else if (r_count == c_last_cnt) begin
                        w_trig_nxt  = 1'b1;
                        w_count_nxt = 16'd0;
                        w_state_nxt = c_st_closed;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_st_disabled;
                    w_count_nxt = 16'd0;
                end
            endcase
        end
    end

    // Watchdog state, counter, trigger pulse and saturating pulse counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_disabled;
            r_count   <= 16'd0;
            r_trigger <= 1'b0;
            r_expire  <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_trigger <= w_trig_nxt;
            if (w_trig_nxt && (r_expire != 8'hFF)) begin
                r_expire <= r_expire + 8'd1;
            end
        end
    end

    // Sticky early-kick flag; a new early kick beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_early <= 1'b0;
        end else if (w_early_set) begin
            r_early <= 1'b1;
        end else if (fault_clr) begin
            r_early <= 1'b0;
        end
    end

    // Per-source debounce: consecutive-high counter, saturating at DEBOUNCE
    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_debounce
            logic [3:0] r_db_cnt;

            assign w_set[i] = fault_src[i] && (r_db_cnt == c_db_pre);

            // Count high cycles; any low cycle restarts the run
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_db_cnt <= 4'd0;
                end else if (!fault_src[i]) begin
                    r_db_cnt <= 4'd0;
                end else if (r_db_cnt != DEBOUNCE) begin
                    r_db_cnt <= r_db_cnt + 4'd1;
                end
            end
        end
    endgenerate

    // Sticky fault status and masked fault level; set wins over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status      <= '0;
            r_fault_input <= 1'b0;
        end else begin
            r_status      <= (fault_clr ? '0 : r_status) | w_set;
            r_fault_input <= |(r_status & ~fault_mask);
        end
    end

    assign wdg_trigger  = r_trigger;
    assign fault_input  = r_fault_input;
    assign fault_status = r_status;
    assign early_kick   = r_early;
    assign wdg_count    = r_count;
    assign expire_cnt   = r_expire;

endmodule
`default_nettype wire

// File: tb/tb_xenos_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xenos_watchdog
//  Description : Self-checking bench for xenos_watchdog with a behavioural
//                reference model compared every cycle plus directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xenos_watchdog;

    localparam int c_ns = 4;
    localparam int c_to = 20;
    localparam int c_wm = 5;
    localparam int c_db = 3;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            enable     = 1'b0;
    logic            kick       = 1'b0;
    logic [c_ns-1:0] fault_src  = '0;
    logic [c_ns-1:0] fault_mask = '0;
    logic            fault_clr  = 1'b0;
    logic            wdg_trigger;
    logic            fault_input;
    logic [c_ns-1:0] fault_status;
    logic            early_kick;
    logic [15:0]     wdg_count;
    logic [7:0]      expire_cnt;

    xenos_watchdog #(
        .N_SRC    (c_ns),
        .WIN_MIN  (16'd5),
        .TIMEOUT  (16'd20),
        .DEBOUNCE (4'd3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .kick         (kick),
        .fault_src    (fault_src),
        .fault_mask   (fault_mask),
        .fault_clr    (fault_clr),
        .wdg_trigger  (wdg_trigger),
        .fault_input  (fault_input),
        .fault_status (fault_status),
        .early_kick   (early_kick),
        .wdg_count    (wdg_count),
        .expire_cnt   (expire_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: "running" flag plus window position; early/valid/expiry
    // decided purely from where the position sits relative to the window.
    bit              m_run    = 1'b0;
    int              m_pos    = 0;
    bit              m_trig   = 1'b0;
    bit              m_early  = 1'b0;
    int              m_pulses = 0;
    bit              m_ambig  = 1'b0;
    int              m_high [c_ns];
    logic [c_ns-1:0] m_status = '0;
    bit              m_fi     = 1'b0;

    initial begin
        for (int i = 0; i < c_ns; i++) m_high[i] = 0;
    end

    always @(posedge clk) begin : model
        logic [c_ns-1:0] newly;
        bit              early_now;
        if (rst) begin
            m_run = 0; m_pos = 0; m_trig = 0; m_early = 0; m_pulses = 0;
            m_ambig = 0; m_status = '0; m_fi = 0;
            for (int i = 0; i < c_ns; i++) m_high[i] = 0;
        end else begin
            early_now = 0;
            m_trig    = 0;
            if (!enable) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0;
            end else if (kick) begin
                if (m_pos < c_wm) begin
                    m_trig = 1; early_now = 1; m_ambig = 1;
                end
                m_pos = 0;
            end else if (m_pos == c_to - 1) begin
                m_trig = 1; m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            if (early_now) m_early = 1;
            else if (fault_clr) m_early = 0;
            if (m_trig && m_pulses < 255) m_pulses = m_pulses + 1;
            m_fi = |(m_status & ~fault_mask);
            newly = '0;
            for (int i = 0; i < c_ns; i++) begin
                m_high[i] = fault_src[i] ? m_high[i] + 1 : 0;
                newly[i]  = (m_high[i] == c_db);
            end
            m_status = (fault_clr ? '0 : m_status) | newly;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_trigger", wdg_trigger, m_trig);
            chk("m_count", wdg_count, m_pos);
            chk("m_early", early_kick, m_early);
            chk("m_status", fault_status, m_status);
            chk("m_fault_input", fault_input, m_fi);
            if (!m_ambig) chk("m_expire_cnt", expire_cnt, m_pulses);
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    bit vk_trig;
    int vk_max;

    initial begin
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("rst_trigger", wdg_trigger, 0);
        chk("rst_count", wdg_count, 0);
        chk("rst_expire", expire_cnt, 0);
        chk("rst_status", fault_status, 0);
        chk("rst_fault_input", fault_input, 0);
        chk("rst_early", early_kick, 0);

        // Expiry: first pulse 21 cycles after enable is sampled, then every 20
        rst    = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i > 1 && (i % 20) == 1) begin
                chk("expiry_trigger", wdg_trigger, 1);
                chk("expiry_count", expire_cnt, (i - 1) / 20);
                chk("expiry_restart", wdg_count, 0);
            end else begin
                chk("expiry_trigger", wdg_trigger, 0);
            end
        end
        chk("expiry_pos70", wdg_count, 9);

        // Valid kicks every 10 cycles
        vk_trig = 0;
        vk_max  = 0;
        for (int i = 0; i < 100; i++) begin
            kick = ((i % 10) == 0);
            tick();
            if (wdg_trigger) vk_trig = 1;
            if (int'(wdg_count) > vk_max) vk_max = int'(wdg_count);
        end
        kick = 1'b0;
        chk("valid_no_trigger", vk_trig, 0);
        chk("valid_early", early_kick, 0);
        chk("valid_max_count", vk_max, 9);

        // Early kick at count 2
        kick = 1'b1; tick(); kick = 1'b0;
        tick(); tick();
        chk("early_pre_count", wdg_count, 2);
        kick = 1'b1; tick(); kick = 1'b0;
        chk("early_trigger", wdg_trigger, 1);
        chk("early_flag", early_kick, 1);
        chk("early_count", wdg_count, 0);
        tick();
        chk("early_trigger_single", wdg_trigger, 0);

        // Kick exactly at window open (count 5) is valid
        repeat (4) tick();
        chk("win5_pre_count", wdg_count, 5);
        kick = 1'b1; tick(); kick = 1'b0;
        chk("win5_trigger", wdg_trigger, 0);
        chk("win5_count", wdg_count, 0);

        // Kick at count 19 (last cycle before expiry) is valid
        repeat (19) tick();
        chk("last_pre_count", wdg_count, 19);
        kick = 1'b1; tick(); kick = 1'b0;
        chk("last_trigger", wdg_trigger, 0);
        chk("last_count", wdg_count, 0);

        // Clear the sticky early flag
        fault_clr = 1'b1; tick(); fault_clr = 1'b0;
        chk("clr_early", early_kick, 0);

        // Debounce: 2-cycle glitch must not latch
        fault_src = 4'b0010; tick(); tick();
        fault_src = 4'b0000; tick();
        chk("glitch_status", fault_status, 4'b0000);
        fault_src = 4'b0010; tick(); tick(); tick();
        chk("db_status", fault_status, 4'b0010);
        chk("db_input_lag", fault_input, 0);
        fault_src = 4'b0000; tick();
        chk("db_input", fault_input, 1);

        // Mask, then clear coinciding with src[2] completing debounce
        fault_mask = 4'b0010; tick();
        chk("mask_input", fault_input, 0);
        fault_src = 4'b0100; tick(); tick();
        fault_clr = 1'b1; tick();
        fault_clr = 1'b0; fault_src = 4'b0000;
        chk("clr_set_status", fault_status, 4'b0100);
        tick();
        chk("clr_set_input", fault_input, 1);
        fault_mask = 4'b0110; tick();
        chk("mask2_input", fault_input, 0);
        fault_mask = 4'b0000;

        // Disable at count 19: no trigger, counter held at 0
        enable = 1'b0; tick();
        enable = 1'b1; tick();
        chk("dis_restart", wdg_count, 0);
        repeat (19) tick();
        chk("dis_pre_count", wdg_count, 19);
        enable = 1'b0; tick();
        chk("dis_trigger", wdg_trigger, 0);
        chk("dis_count", wdg_count, 0);
        tick();
        chk("dis_hold_trigger", wdg_trigger, 0);
        chk("dis_hold_count", wdg_count, 0);

        // Reset at count 19: everything back to zero
        enable = 1'b1; tick();
        repeat (19) tick();
        chk("rst_pre_count", wdg_count, 19);
        chk("rst_pre_status", fault_status, 4'b0100);
        rst = 1'b1; tick();
        chk("mid_rst_trigger", wdg_trigger, 0);
        chk("mid_rst_count", wdg_count, 0);
        chk("mid_rst_expire", expire_cnt, 0);
        chk("mid_rst_status", fault_status, 0);
        chk("mid_rst_input", fault_input, 0);
        chk("mid_rst_early", early_kick, 0);
        rst = 1'b0; enable = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
